sbox_arbiter: RTL

SBOX_ARBITER -- requirements
Module: sbox_arbiter

---
 rtl/aes_pkg.sv | 23 ++
 rtl/sbox_tag_pipe.sv | 44 ++++
 rtl/sbox_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants for the S-box arbiter slice. It holds the
//               token tag encodings, the default S-box read latency and the
//               request/response data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Default S-box read latency in clk cycles (legal range 1..3)
    localparam int   ROM_LAT_DEF = 1;

    // Request/response widths: cipher-round state and key-schedule word
    localparam int   RD_W        = 128;
    localparam int   KS_W        = 32;

    // Tag carried with each in-flight lookup, identifying the requester
    localparam logic TAG_RD      = 1'b0;
    localparam logic TAG_KS      = 1'b1;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_tag_pipe
// Description : DEPTH-stage delay line for {valid, tag} lookup tokens. A token
//               presented on in_* appears on out_* DEPTH cycles later. Reset
//               drops every token in flight.
// Ports       : clk, rst_n        - clock, async active-low reset
//               in_valid, in_tag  - token entering the line
//               out_valid, out_tag- token leaving the line
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_tag,
    output logic out_valid,
    output logic out_tag
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];

endmodule : sbox_tag_pipe
`default_nettype wire

// File: rtl/sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sbox_arbiter
// Description : Shares one 128-bit S-box between the cipher-round SubBytes
//               path (rd) and the key-schedule SubWord path (ks). One grant
//               per cycle, fully pipelined; responses pulse ROM_LAT+1 cycles
//               after the accepting handshake with no backpressure.
// Config      : SBOX_ARB_RR_EN defined   -> round-robin on contention,
//                                           rd first after reset
//               SBOX_ARB_RR_EN undefined -> fixed priority, ks over rd
// Ports       : clk, rst_n                       - clock, async active-low reset
//               rd_req_valid/ready/data          - 128-bit request
//               rd_rsp_valid/data                - 128-bit response
//               ks_req_valid/ready/word          - 32-bit request
//               ks_rsp_valid/word                - 32-bit response
//               sbox_addr (out) / sbox_value (in)- shared S-box port
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_arbiter
    import aes_pkg::*;
#(
    parameter int ROM_LAT = ROM_LAT_DEF      // legal 1..3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req_valid,
    output logic            rd_req_ready,
    input  logic [RD_W-1:0] rd_req_data,
    output logic            rd_rsp_valid,
    output logic [RD_W-1:0] rd_rsp_data,
    input  logic            ks_req_valid,
    output logic            ks_req_ready,
    input  logic [KS_W-1:0] ks_req_word,
    output logic            ks_rsp_valid,
    output logic [KS_W-1:0] ks_rsp_word,
    output logic [RD_W-1:0] sbox_addr,
    input  logic [RD_W-1:0] sbox_value
);

    logic r_run;            // low through reset and until the first edge after release
    logic w_rd_win;
    logic w_ks_win;
    logic w_rd_fire;
    logic w_ks_fire;
    logic w_tok_valid;
    logic w_tok_tag;
    logic r_rd_rsp_valid;
    logic r_ks_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

`ifdef SBOX_ARB_RR_EN
    // r_ks_turn: ks wins the next contended cycle. Cleared so rd wins first.
    logic r_ks_turn;

    assign w_ks_win = ks_req_valid & (~rd_req_valid | r_ks_turn);
    assign w_rd_win = rd_req_valid & (~ks_req_valid | ~r_ks_turn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ks_turn <= 1'b0;
        else if (r_run && rd_req_valid && ks_req_valid)
            r_ks_turn <= ~r_ks_turn;
    end
`else
    assign w_ks_win = ks_req_valid;
    assign w_rd_win = rd_req_valid & ~ks_req_valid;
`endif

    assign rd_req_ready = r_run & w_rd_win;
    assign ks_req_ready = r_run & w_ks_win;
    assign w_rd_fire    = rd_req_valid & rd_req_ready;
    assign w_ks_fire    = ks_req_valid & ks_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sbox_addr <= '0;
        else if (w_rd_fire)
            sbox_addr <= rd_req_data;
        else if (w_ks_fire)
            sbox_addr <= {{(RD_W-KS_W){1'b0}}, ks_req_word};
    end

    assign w_tok_valid = w_rd_fire | w_ks_fire;
    assign w_tok_tag   = w_ks_fire ? TAG_KS : TAG_RD;

    // The token leaves the line ROM_LAT cycles after the handshake; the
    // response register adds the cycle that sbox_addr itself spends.
    logic w_pipe_valid;
    logic w_pipe_tag;

    sbox_tag_pipe #(
        .DEPTH     (ROM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_tok_valid),
        .in_tag    (w_tok_tag),
        .out_valid (w_pipe_valid),
        .out_tag   (w_pipe_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_rsp_valid <= 1'b0;
            r_ks_rsp_valid <= 1'b0;
        end else begin
            r_rd_rsp_valid <= w_pipe_valid & (w_pipe_tag == TAG_RD);
            r_ks_rsp_valid <= w_pipe_valid & (w_pipe_tag == TAG_KS);
        end
    end

    assign rd_rsp_valid = r_rd_rsp_valid;
    assign ks_rsp_valid = r_ks_rsp_valid;
    assign rd_rsp_data  = r_rd_rsp_valid ? sbox_value : '0;
    assign ks_rsp_word  = r_ks_rsp_valid ? sbox_value[KS_W-1:0] : '0;

endmodule : sbox_arbiter
`default_nettype wire
